feature_vector_builder: RTL and testbench
=========================================

Name: feature_vector_builder

Overview:
- Producer side of the logistic-regression feature interface.
- Accepts a serial stream of 32-bit feature samples from the line buffer and assembles them into a registered 41-entry parallel vector `xarray[0:40]`.
- Presents the vector to the combinational inner-product stage, which forms `hprime`, using a valid/ready handoff.
- Holds the vector stable until the consumer takes it, then refills.

Parameters:
- NFEAT, 41, number of vector entries (indices 0..NFEAT-1).
- DW, 32, bit width of each entry and of the stream data.
- FIRST_FEAT, 2, first index loaded from the stream; entries below it are always driven 0 (index 0 is bias-handled downstream, index 1 is unused).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  stream sample valid.
- s_data  in  DW  stream sample.
- s_last  in  1  marks the final sample of a frame; qualified by s_valid.
- s_ready  out  1  builder can accept a sample.
- xarray  out  DW x NFEAT  unpacked array [0:NFEAT-1] of the assembled vector.
- v_valid  out  1  xarray holds a complete vector.
- v_ready  in  1  consumer accepts the vector this cycle.
- short_err  out  1  sticky: a frame ended (s_last) before index NFEAT-1.

Behaviour:
- Reset (async assert, sync deassert via clk):
  - state=FILL, idx=FIRST_FEAT.
  - All xarray entries 0, v_valid=0, short_err=0.
  - s_ready=1 after reset is released.
- States: FILL (collecting samples), HOLD (vector presented).
- s_ready = (state==FILL); it is combinational from state only, with no dependence on s_valid.
- Accept = s_valid && s_ready. Handoff = v_valid && v_ready.
- FILL, on accept:
  - xarray[idx] <= s_data.
  - If idx==NFEAT-1 (s_last may be 0 or 1): go to HOLD, v_valid<=1, idx<=FIRST_FEAT.
  - Else if s_last=1 (short frame):
    - Entries idx+1..NFEAT-1 <= 0 on the same edge.
    - short_err<=1.
    - Go to HOLD, v_valid<=1, idx<=FIRST_FEAT.
  - Else idx<=idx+1.
- FILL without accept: all state held.
- HOLD:
  - s_ready=0; xarray and v_valid are held stable regardless of stream inputs.
  - On handoff: v_valid<=0, state<=FILL.
  - No sample is accepted in the handoff cycle.
- v_valid is registered and rises on the edge that accepts the last sample, i.e. zero added cycles after the final accept.
- Minimum vector period: (NFEAT-FIRST_FEAT) accept cycles + 1 handoff cycle = 40 cycles at defaults.
- Entries 0..FIRST_FEAT-1 are constant 0; they are never written.
- After handoff, xarray keeps its old contents until each entry is overwritten; stale values are never visible with v_valid=1.
- s_last on a sample arriving in FILL with idx==FIRST_FEAT yields a vector containing one sample with the rest zero-padded; short_err is set.
- short_err is cleared only by reset.
- v_ready asserted while v_valid=0 is ignored.
- Reset asserted mid-frame or in HOLD: all state is discarded immediately, with the reset values above.
- idx width is clog2(NFEAT); it never exceeds NFEAT-1.
- No arithmetic on data; the path is a pure register load.

Optional Feature:
- Macro: FEATURE_VECTOR_BUILDER_VEC_CNT_EN.
- Defined:
  - Adds output port vec_cnt (16 bits), reset 0, incremented by 1 on each handoff.
  - Wraps 0xFFFF->0x0000.
  - Short frames are counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Full frame: stream 2..40 (value k at index k), s_last on 40, v_ready=0 → v_valid=1 on the edge after the 39th accept; xarray[0]=xarray[1]=0, xarray[k]=k; s_ready=0; vector held for 10 cycles; then v_ready=1 for 1 cycle → v_valid=0, s_ready=1 next cycle.
- Backpressure/gaps: same data with s_valid toggling every other cycle → identical xarray; no sample lost or duplicated; samples presented in HOLD are not accepted (s_ready=0).
- Short frame: samples 0xA,0xB,0xC with s_last on 0xC → xarray[2..4]=A,B,C, xarray[5..40]=0, v_valid=1, short_err=1 and stays 1 across the next full frame.
- Back-to-back: two full frames with v_ready tied 1 → second vector's first accept occurs 1 cycle after the first handoff; 80-cycle total for two vectors; the second xarray is correct.
- Reset mid-frame: assert rst_n=0 after 20 accepts → xarray all 0, v_valid=0; after release, a full frame produces a correct vector starting at index 2.
- With FEATURE_VECTOR_BUILDER_VEC_CNT_EN: 3 handoffs → vec_cnt=3; preload via 65536 handoffs → wraps to 0.

Source files
------------

// File: rtl/feature_vector_builder.sv
// rtl/feature_vector_builder.sv - serial-to-parallel feature vector builder with valid/ready handoff
// Optional handoff counter port vec_cnt is enabled by defining FEATURE_VECTOR_BUILDER_VEC_CNT_EN.
module feature_vector_builder #(
  parameter int NFEAT      = 41,
  parameter int DW         = 32,
  parameter int FIRST_FEAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic [DW-1:0] xarray [0:NFEAT-1],
  output logic          v_valid,
  input  logic          v_ready,
  output logic          short_err
`ifdef FEATURE_VECTOR_BUILDER_VEC_CNT_EN
  ,
  output logic [15:0]   vec_cnt
`endif
);

  localparam int            IW        = $clog2(NFEAT);
  localparam logic [IW-1:0] FIRST_IDX = IW'(FIRST_FEAT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NFEAT - 1);
  localparam logic [0:0]    ST_FILL   = 1'b0;
  localparam logic [0:0]    ST_HOLD   = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_idx;
  logic          r_v_valid;
  logic          r_short_err;
  logic          w_accept;
  logic          w_handoff;
  logic          w_last_idx;

  assign s_ready    = (r_state == ST_FILL);
  assign w_accept   = s_valid && s_ready;
  assign w_handoff  = r_v_valid && v_ready;
  assign w_last_idx = (r_idx == LAST_IDX);
  assign v_valid    = r_v_valid;
  assign short_err  = r_short_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_idx       <= FIRST_IDX;
      r_v_valid   <= 1'b0;
      r_short_err <= 1'b0;
    end else if (w_accept) begin
      if (w_last_idx || s_last) begin
        r_state   <= ST_HOLD;
        r_v_valid <= 1'b1;
        r_idx     <= FIRST_IDX;
        // s_last landing exactly on the final index is a normal full frame
        if (!w_last_idx) begin
          r_short_err <= 1'b1;
        end
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end else if ((r_state == ST_HOLD) && w_handoff) begin
      r_state   <= ST_FILL;
      r_v_valid <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NFEAT; gi++) begin : g_entry
      if (gi < FIRST_FEAT) begin : g_zero
        assign xarray[gi] = '0;
      end else begin : g_reg
        logic [DW-1:0] r_entry;
        // A short frame zero-pads every entry above the closing index on the same edge
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_entry <= '0;
          end else if (w_accept) begin
            if (r_idx == IW'(gi)) begin
              r_entry <= s_data;
            end else if (s_last && (r_idx < IW'(gi))) begin
              r_entry <= '0;
            end
          end
        end
        assign xarray[gi] = r_entry;
      end
    end
  endgenerate

`ifdef FEATURE_VECTOR_BUILDER_VEC_CNT_EN
  logic [15:0] r_vec_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt <= '0;
    end else if (w_handoff) begin
      r_vec_cnt <= r_vec_cnt + 16'd1;
    end
  end

  assign vec_cnt = r_vec_cnt;
`endif

endmodule

// File: tb/tb_feature_vector_builder.sv
// tb/tb_feature_vector_builder.sv - directed and randomized checks of feature_vector_builder
module tb_feature_vector_builder;

  localparam int NFEAT      = 41;
  localparam int DW         = 32;
  localparam int FIRST_FEAT = 2;
  localparam int NSAMP      = NFEAT - FIRST_FEAT;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_last  = 1'b0;
  logic          s_ready;
  logic [DW-1:0] xarray [0:NFEAT-1];
  logic          v_valid;
  logic          v_ready = 1'b0;
  logic          short_err;
`ifdef FEATURE_VECTOR_BUILDER_VEC_CNT_EN
  logic [15:0]   vec_cnt;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_vec [0:NFEAT-1];
  logic [DW-1:0] q_data [$];
  logic [DW-1:0] q_two [$];
  logic          m_short = 1'b0;
  int            m_cnt   = 0;

  always #5 clk = ~clk;

  feature_vector_builder #(
    .NFEAT      (NFEAT),
    .DW         (DW),
    .FIRST_FEAT (FIRST_FEAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .xarray    (xarray),
    .v_valid   (v_valid),
    .v_ready   (v_ready),
    .short_err (short_err)
`ifdef FEATURE_VECTOR_BUILDER_VEC_CNT_EN
    ,
    .vec_cnt   (vec_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector: samples in arrival order from FIRST_FEAT upward, everything else zero
  task automatic build_exp();
    for (int i = 0; i < NFEAT; i++) exp_vec[i] = '0;
    for (int j = 0; j < q_data.size(); j++) exp_vec[FIRST_FEAT + j] = q_data[j];
  endtask

  task automatic check_vec(input string tag);
    for (int i = 0; i < NFEAT; i++) chk($sformatf("%s[%0d]", tag, i), xarray[i], exp_vec[i]);
  endtask

  task automatic check_cnt();
`ifdef FEATURE_VECTOR_BUILDER_VEC_CNT_EN
    chk("vec_cnt", 32'(vec_cnt), 32'(m_cnt & 16'hFFFF));
`endif
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every sample, 2 random 0..2 idle cycles
  task automatic send_frame(input int gap_mode, input logic last_on_full, input int hold_cycles);
    int n;
    int gaps;
    n = q_data.size();
    build_exp();
    for (int j = 0; j < n; j++) begin
      gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        s_last  = 1'($urandom_range(0, 1));
        v_ready = 1'($urandom_range(0, 1));
        tick();
        chk1("s_ready_gap", s_ready, 1'b1);
      end
      s_valid = 1'b1;
      s_data  = q_data[j];
      s_last  = (j == n - 1) ? ((n < NSAMP) ? 1'b1 : last_on_full) : 1'b0;
      v_ready = 1'($urandom_range(0, 1));
      chk1("s_ready_fill", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      v_ready = 1'b0;
      if (j < n - 1) chk1("v_valid_early", v_valid, 1'b0);
    end
    if (n < NSAMP) m_short = 1'b1;
    chk1("v_valid_rise", v_valid, 1'b1);
    chk1("s_ready_hold", s_ready, 1'b0);
    chk1("short_err", short_err, m_short);
    check_vec("vec");
    for (int h = 0; h < hold_cycles; h++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      s_last  = 1'($urandom_range(0, 1));
      v_ready = 1'b0;
      tick();
      chk1("v_valid_hold", v_valid, 1'b1);
      chk1("s_ready_hold", s_ready, 1'b0);
      check_vec("vec_hold");
    end
    // A sample offered in the handoff cycle must not be taken
    s_valid = 1'($urandom_range(0, 1));
    s_data  = $urandom;
    s_last  = 1'b0;
    v_ready = 1'b1;
    tick();
    m_cnt++;
    s_valid = 1'b0;
    v_ready = 1'b0;
    chk1("v_valid_fall", v_valid, 1'b0);
    chk1("s_ready_refill", s_ready, 1'b1);
    check_cnt();
  endtask

  task automatic load_ramp();
    q_data.delete();
    for (int k = FIRST_FEAT; k < NFEAT; k++) q_data.push_back(DW'(k));
  endtask

  task automatic load_random(input int n);
    q_data.delete();
    for (int k = 0; k < n; k++) q_data.push_back($urandom);
  endtask

  initial begin
    int p;
    int n;
    logic exp_ready;

    rst_n = 1'b0;
    q_data.delete();
    build_exp();
    tick();
    tick();
    chk1("rst_v_valid", v_valid, 1'b0);
    chk1("rst_short_err", short_err, 1'b0);
    check_vec("rst_vec");
    rst_n = 1'b1;
    tick();
    chk1("rst_s_ready", s_ready, 1'b1);
    check_cnt();

    load_ramp();
    send_frame(0, 1'b1, 10);

    load_ramp();
    send_frame(1, 1'b0, 3);

    q_data.delete();
    q_data.push_back(32'hA);
    q_data.push_back(32'hB);
    q_data.push_back(32'hC);
    send_frame(2, 1'b1, 2);

    load_ramp();
    send_frame(2, 1'b1, 1);

    // Back-to-back: one vector every NSAMP+1 cycles with v_ready tied high
    load_random(NSAMP);
    q_two = q_data;
    load_random(NSAMP);
    q_two = {q_two, q_data};
    p = 0;
    v_ready = 1'b1;
    for (int e = 1; e <= 2 * (NSAMP + 1); e++) begin
      exp_ready = (e != NSAMP + 1) && (e != 2 * (NSAMP + 1));
      chk1("b2b_s_ready", s_ready, exp_ready);
      s_valid = 1'b1;
      s_data  = (p < 2 * NSAMP) ? q_two[p] : $urandom;
      s_last  = (p == NSAMP - 1);
      tick();
      if (exp_ready) p++;
      if (e == NSAMP || e == 2 * NSAMP + 1) begin
        q_data.delete();
        for (int k = 0; k < NSAMP; k++) q_data.push_back(q_two[(e == NSAMP) ? k : NSAMP + k]);
        build_exp();
        chk1("b2b_v_valid", v_valid, 1'b1);
        check_vec("b2b_vec");
      end
      if (e == NSAMP + 1 || e == 2 * (NSAMP + 1)) chk1("b2b_v_fall", v_valid, 1'b0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    v_ready = 1'b0;
    m_cnt += 2;
    chk("b2b_accepts", 32'(p), 32'(2 * NSAMP));
    check_cnt();

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, NSAMP));
      load_random(n);
      send_frame(2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    // Asynchronous reset part-way through a frame
    load_random(NSAMP);
    for (int j = 0; j < 20; j++) begin
      s_valid = 1'b1;
      s_data  = q_data[j];
      tick();
    end
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q_data.delete();
    build_exp();
    m_short = 1'b0;
    m_cnt   = 0;
    chk1("midrst_v_valid", v_valid, 1'b0);
    chk1("midrst_short_err", short_err, 1'b0);
    check_vec("midrst_vec");
    tick();
    rst_n = 1'b1;
    tick();
    chk1("midrst_s_ready", s_ready, 1'b1);
    check_cnt();
    load_ramp();
    send_frame(0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
